// File: rtl/lch_pkg.sv
// Shared encodings for the channel-LLR ping-pong controller.
// Covers the half-buffer states and the writer and decoder FSM states.
package lch_pkg;

    localparam int NUM_HALVES = 2;

    typedef enum logic [1:0] {
        H_EMPTY = 2'd0,
        H_FILL  = 2'd1,
        H_FULL  = 2'd2,
        H_DEC   = 2'd3
    } half_st_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_st_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_BUSY = 1'b1
    } dec_st_e;

endpackage

// File: rtl/lch_half_state.sv
// Per-half state and frame-id storage. Writer and decoder requests are applied in one edge.
// full_cnt is computed from the next-state values so it changes in the same edge as the halves.
module lch_half_state
    import lch_pkg::*;
#(
    parameter int FID_W = 8
)
(
    input  logic                                wrclk,
    input  logic                                reset,
    input  logic                                wr_arm,
    input  logic                                wr_fill_done,
    input  logic                                wr_abort,
    input  logic                                wr_idx,
    input  logic [FID_W-1:0]                    wr_fid,
    input  logic                                rd_take,
    input  logic                                rd_free,
    input  logic                                rd_idx,
    output logic [NUM_HALVES-1:0][1:0]          half_st,
    output logic [NUM_HALVES-1:0][FID_W-1:0]    half_fid,
    output logic [1:0]                          full_cnt
);

    logic [NUM_HALVES-1:0][1:0]       half_st_q,  half_st_d;
    logic [NUM_HALVES-1:0][FID_W-1:0] half_fid_q, half_fid_d;
    logic [1:0]                       full_cnt_q, full_cnt_d;

    always_comb begin
        half_st_d  = half_st_q;
        half_fid_d = half_fid_q;
        full_cnt_d = 2'd0;
        for (int h = 0; h < NUM_HALVES; h++) begin
            // The two FSMs only ever target different halves, so both updates can land together.
            if (wr_idx == 1'(h)) begin
                if (wr_arm) begin
                    half_st_d[h] = H_FILL;
                end else if (wr_fill_done) begin
                    half_st_d[h]  = H_FULL;
                    half_fid_d[h] = wr_fid;
                end else if (wr_abort) begin
                    half_st_d[h] = H_EMPTY;
                end
            end
            if (rd_idx == 1'(h)) begin
                if (rd_take) begin
                    half_st_d[h] = H_DEC;
                end else if (rd_free) begin
                    half_st_d[h] = H_EMPTY;
                end
            end
            if (half_st_d[h] == H_FULL || half_st_d[h] == H_DEC) begin
                full_cnt_d = full_cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge wrclk) begin
        if (reset) begin
            half_st_q  <= '0;
            half_fid_q <= '0;
            full_cnt_q <= 2'd0;
        end else begin
            half_st_q  <= half_st_d;
            half_fid_q <= half_fid_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    assign half_st  = half_st_q;
    assign half_fid = half_fid_q;
    assign full_cnt = full_cnt_q;

endmodule

// File: rtl/lch_pingpong_ctrl.sv
// Ping-pong sequencer for the Lch buffer: arms the writer on a free half, hands full halves
// to the decoder, counts beats dropped while no half is armed and aborts stalled fills.
module lch_pingpong_ctrl
    import lch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int FID_W       = 8,
    parameter int DROP_W      = 16
)
(
    input  logic              wrclk,
    input  logic              reset,
    input  logic              frame_lock,
    input  logic              input_en,
    input  logic              wr_done,
    input  logic              dec_done,
    output logic              start_read,
    output logic              wr_addr_high,
    output logic              dec_start,
    output logic              dec_half,
    output logic [FID_W-1:0]  dec_fid,
    output logic [1:0]        full_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow,
    output logic              err_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    wr_st_e              w_st_q, w_st_d;
    dec_st_e             d_st_q, d_st_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [FID_W-1:0]    fid_cnt_q, fid_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                start_read_q, start_read_d;
    logic                wr_addr_high_q, wr_addr_high_d;
    logic                err_timeout_q, err_timeout_d;
    logic                dec_start_q, dec_start_d;
    logic                dec_half_q, dec_half_d;
    logic [FID_W-1:0]    dec_fid_q, dec_fid_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic wr_arm, wr_fill_done, wr_abort, rd_take, rd_free;
    logic [NUM_HALVES-1:0][1:0]       half_st;
    logic [NUM_HALVES-1:0][FID_W-1:0] half_fid;

    lch_half_state #(.FID_W(FID_W)) u_half (
        .wrclk        (wrclk),
        .reset        (reset),
        .wr_arm       (wr_arm),
        .wr_fill_done (wr_fill_done),
        .wr_abort     (wr_abort),
        .wr_idx       (wr_ptr_q),
        .wr_fid       (fid_cnt_q),
        .rd_take      (rd_take),
        .rd_free      (rd_free),
        .rd_idx       (rd_ptr_q),
        .half_st      (half_st),
        .half_fid     (half_fid),
        .full_cnt     (full_cnt)
    );

    always_comb begin
        w_st_d         = w_st_q;
        wr_ptr_d       = wr_ptr_q;
        fid_cnt_d      = fid_cnt_q;
        idle_d         = idle_q;
        start_read_d   = start_read_q;
        wr_addr_high_d = wr_addr_high_q;
        err_timeout_d  = 1'b0;
        wr_arm         = 1'b0;
        wr_fill_done   = 1'b0;
        wr_abort       = 1'b0;
        case (w_st_q)
            W_IDLE: begin
                if (half_st[wr_ptr_q] == H_EMPTY) begin
                    wr_arm         = 1'b1;
                    start_read_d   = 1'b1;
                    wr_addr_high_d = wr_ptr_q;
                    idle_d         = '0;
                    w_st_d         = W_FILL;
                end
            end
            W_FILL: begin
                // A completion in the timeout cycle still counts as a good fill.
                if (wr_done) begin
                    wr_fill_done = 1'b1;
                    fid_cnt_d    = fid_cnt_q + FID_W'(1);
                    wr_ptr_d     = ~wr_ptr_q;
                    start_read_d = 1'b0;
                    w_st_d       = W_IDLE;
                end else if (input_en) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    wr_abort      = 1'b1;
                    start_read_d  = 1'b0;
                    err_timeout_d = 1'b1;
                    w_st_d        = W_IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: w_st_d = W_IDLE;
        endcase
    end

    always_comb begin
        d_st_d      = d_st_q;
        rd_ptr_d    = rd_ptr_q;
        dec_start_d = 1'b0;
        dec_half_d  = dec_half_q;
        dec_fid_d   = dec_fid_q;
        rd_take     = 1'b0;
        rd_free     = 1'b0;
        case (d_st_q)
            D_IDLE: begin
                if (half_st[rd_ptr_q] == H_FULL) begin
                    rd_take     = 1'b1;
                    dec_start_d = 1'b1;
                    dec_half_d  = rd_ptr_q;
                    dec_fid_d   = half_fid[rd_ptr_q];
                    d_st_d      = D_BUSY;
                end
            end
            D_BUSY: begin
                if (dec_done) begin
                    rd_free  = 1'b1;
                    rd_ptr_d = ~rd_ptr_q;
                    d_st_d   = D_IDLE;
                end
            end
            default: d_st_d = D_IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (frame_lock && input_en && !start_read_q) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge wrclk) begin
        if (reset) begin
            w_st_q         <= W_IDLE;
            d_st_q         <= D_IDLE;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fid_cnt_q      <= '0;
            idle_q         <= '0;
            start_read_q   <= 1'b0;
            wr_addr_high_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            dec_start_q    <= 1'b0;
            dec_half_q     <= 1'b0;
            dec_fid_q      <= '0;
            drop_cnt_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            w_st_q         <= w_st_d;
            d_st_q         <= d_st_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fid_cnt_q      <= fid_cnt_d;
            idle_q         <= idle_d;
            start_read_q   <= start_read_d;
            wr_addr_high_q <= wr_addr_high_d;
            err_timeout_q  <= err_timeout_d;
            dec_start_q    <= dec_start_d;
            dec_half_q     <= dec_half_d;
            dec_fid_q      <= dec_fid_d;
            drop_cnt_q     <= drop_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    // Writer and decoder must never hold the same half.
    a_no_shared_half: assert property (@(posedge wrclk) disable iff (reset)
        !((w_st_q == W_FILL) && (d_st_q == D_BUSY) && (wr_ptr_q == rd_ptr_q)));

    assign start_read   = start_read_q;
    assign wr_addr_high = wr_addr_high_q;
    assign dec_start    = dec_start_q;
    assign dec_half     = dec_half_q;
    assign dec_fid      = dec_fid_q;
    assign drop_cnt     = drop_cnt_q;
    assign overflow     = overflow_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_lch_pingpong_ctrl.sv
// Directed bench for lch_pingpong_ctrl: stimulus queues expected arm/decode/timeout events,
// a negedge monitor pops and compares them when the DUT raises the matching output.
module tb_lch_pingpong_ctrl;

    localparam int FID_W  = 8;
    localparam int DROP_W = 16;

    logic              wrclk = 1'b0;
    logic              reset, frame_lock, input_en, wr_done, dec_done;
    logic              start_read, wr_addr_high, dec_start, dec_half;
    logic [FID_W-1:0]  dec_fid;
    logic [1:0]        full_cnt;
    logic [DROP_W-1:0] drop_cnt;
    logic              overflow, err_timeout;

    lch_pingpong_ctrl #(.TIMEOUT_CYC(16), .FID_W(FID_W), .DROP_W(DROP_W)) dut (
        .wrclk        (wrclk),
        .reset        (reset),
        .frame_lock   (frame_lock),
        .input_en     (input_en),
        .wr_done      (wr_done),
        .dec_done     (dec_done),
        .start_read   (start_read),
        .wr_addr_high (wr_addr_high),
        .dec_start    (dec_start),
        .dec_half     (dec_half),
        .dec_fid      (dec_fid),
        .full_cnt     (full_cnt),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow),
        .err_timeout  (err_timeout)
    );

    always #5 wrclk = ~wrclk;

    typedef struct {
        int cyc;
        int half;
        int fid;
    } ev_t;

    ev_t exp_arm[$];
    ev_t exp_dec[$];
    int  exp_to[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic sr_prev = 1'b0;

    always @(posedge wrclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wrclk);
        #1;
    endtask

    function automatic ev_t ev(input int c, input int h, input int f);
        ev_t e;
        e.cyc  = c;
        e.half = h;
        e.fid  = f;
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start_read"}, int'(start_read), 0);
        chk({tag, "_wr_addr_high"}, int'(wr_addr_high), 0);
        chk({tag, "_dec_start"}, int'(dec_start), 0);
        chk({tag, "_dec_half"}, int'(dec_half), 0);
        chk({tag, "_dec_fid"}, int'(dec_fid), 0);
        chk({tag, "_full_cnt"}, int'(full_cnt), 0);
        chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_err_timeout"}, int'(err_timeout), 0);
    endtask

    // Monitor: every arm, decode start and timeout pulse must match the next queued expectation.
    always @(negedge wrclk) begin
        if (start_read === 1'b1 && sr_prev !== 1'b1) begin
            if (exp_arm.size() == 0) begin
                chk("arm_unexpected", cyc, -1);
            end else begin
                ev_t e;
                e = exp_arm.pop_front();
                chk("arm_edge", cyc, e.cyc);
                chk("arm_half", int'(wr_addr_high), e.half);
            end
        end
        sr_prev = start_read;
        if (dec_start === 1'b1) begin
            if (exp_dec.size() == 0) begin
                chk("dec_unexpected", cyc, -1);
            end else begin
                ev_t e;
                e = exp_dec.pop_front();
                chk("dec_edge", cyc, e.cyc);
                chk("dec_half", int'(dec_half), e.half);
                chk("dec_fid", int'(dec_fid), e.fid);
            end
        end
        if (err_timeout === 1'b1) begin
            if (exp_to.size() == 0) begin
                chk("timeout_unexpected", cyc, -1);
            end else begin
                chk("timeout_edge", cyc, exp_to.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; frame_lock = 1'b0; input_en = 1'b0; wr_done = 1'b0; dec_done = 1'b0;

        // T1 reset
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all_zero("reset");
        end
        exp_arm.push_back(ev(4, 0, 0));
        reset = 1'b0;
        tick(1);                                   // edge 4
        chk("t1_start_read", int'(start_read), 1);
        chk("t1_wr_addr_high", int'(wr_addr_high), 0);

        // T2 ping-pong
        wr_done = 1'b1;
        exp_dec.push_back(ev(6, 0, 0));
        exp_arm.push_back(ev(6, 1, 0));
        tick(1);                                   // edge 5
        wr_done = 1'b0;
        chk("t2_sr_low", int'(start_read), 0);
        chk("t2_full1", int'(full_cnt), 1);
        tick(1);                                   // edge 6
        chk("t2_full_dec", int'(full_cnt), 1);
        wr_done = 1'b1;
        tick(1);                                   // edge 7
        wr_done = 1'b0;
        chk("t2_full2", int'(full_cnt), 2);
        chk("t2_sr_blocked", int'(start_read), 0);
        tick(2);                                   // edge 9
        chk("t2_sr_still_low", int'(start_read), 0);

        // T3 drop, then free a half
        frame_lock = 1'b1; input_en = 1'b1;
        tick(5);                                   // edge 14
        input_en = 1'b0; frame_lock = 1'b0;
        chk("t3_drop_cnt", int'(drop_cnt), 5);
        chk("t3_overflow", int'(overflow), 1);
        dec_done = 1'b1;
        exp_arm.push_back(ev(16, 0, 0));
        exp_dec.push_back(ev(16, 1, 1));
        tick(1);                                   // edge 15
        dec_done = 1'b0;
        chk("t3_full_after_free", int'(full_cnt), 1);
        tick(1);                                   // edge 16
        chk("t3_rearm", int'(start_read), 1);

        // T4 timeout: no input_en since arming at edge 16
        exp_to.push_back(32);
        exp_arm.push_back(ev(33, 0, 0));
        tick(16);                                  // edge 32
        chk("t4_sr_dropped", int'(start_read), 0);
        chk("t4_full", int'(full_cnt), 1);
        chk("t4_overflow_sticky", int'(overflow), 1);
        tick(1);                                   // edge 33
        chk("t4_rearm_half", int'(wr_addr_high), 0);

        // Fill half 0 (fid must still be 2), free half 1
        wr_done = 1'b1;
        tick(1);                                   // edge 34
        wr_done = 1'b0;
        chk("t4_full2", int'(full_cnt), 2);
        dec_done = 1'b1;
        exp_arm.push_back(ev(36, 1, 0));
        exp_dec.push_back(ev(36, 0, 2));
        tick(1);                                   // edge 35
        dec_done = 1'b0;
        chk("t4_full_freed", int'(full_cnt), 1);
        tick(2);                                   // edge 37

        // T5 wr_done on half 1 and dec_done on half 0 together
        wr_done = 1'b1; dec_done = 1'b1;
        exp_arm.push_back(ev(39, 0, 0));
        exp_dec.push_back(ev(39, 1, 3));
        tick(1);                                   // edge 38
        wr_done = 1'b0; dec_done = 1'b0;
        chk("t5_full_cnt", int'(full_cnt), 1);
        chk("t5_sr_low", int'(start_read), 0);
        tick(2);                                   // edge 40

        // T6 reset while W_FILL and D_BUSY
        reset = 1'b1;
        tick(1);                                   // edge 41
        chk_all_zero("t6");
        reset = 1'b0;
        exp_arm.push_back(ev(42, 0, 0));
        tick(1);                                   // edge 42
        wr_done = 1'b1;
        exp_dec.push_back(ev(44, 0, 0));
        exp_arm.push_back(ev(44, 1, 0));
        tick(1);                                   // edge 43
        wr_done = 1'b0;
        tick(1);                                   // edge 44
        frame_lock = 1'b1; input_en = 1'b1;        // armed: beats are not drops
        tick(2);                                   // edge 46
        frame_lock = 1'b0; input_en = 1'b0;
        chk("t6_no_drop", int'(drop_cnt), 0);
        chk("t6_no_overflow", int'(overflow), 0);
        tick(3);

        chk("left_arm", exp_arm.size(), 0);
        chk("left_dec", exp_dec.size(), 0);
        chk("left_timeout", exp_to.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
